apb_req_scheduler: RTL and testbench
====================================

// Module: apb_req_scheduler
// PURPOSE
//  - Round-robin scheduler that shares the single APB master bridge among NUM_REQ requesters.
//  - Latches one requester's command and drives the bridge's transfer/READ_WRITE/address/data inputs.
//  - Watches PENABLE/PREADY/PSLVERR for completion, then returns read data and error status.
//  - Bounds every transfer with a PREADY timeout.
// PARAMETERS
//  NUM_REQ   2    number of requesters (>=2)
//  TIMEOUT   16   max ACCESS-phase cycles waiting for PREADY before abort (>=1)
//  ADDR_W    9    APB address width; bit 8 selects slave 1/2 in the bridge
//  DATA_W    8    APB data width
// PORTS
//  PCLK               in   1              clock
//  PRESET             in   1              async reset, active-high
//  req                in   NUM_REQ        request, held until rsp_valid for that index
//  req_write          in   NUM_REQ        1=write, 0=read, per requester
//  req_addr           in   NUM_REQ*ADDR_W packed addresses, slice i = requester i
//  req_wdata          in   NUM_REQ*DATA_W packed write data
//  gnt                out  NUM_REQ        one-hot owner of the current transfer
//  rsp_valid          out  NUM_REQ        one-cycle completion pulse to the owner
//  rsp_rdata          out  DATA_W         read data, valid with rsp_valid on a read
//  rsp_err            out  1              error flag, valid with rsp_valid (slave error or timeout)
//  transfer           out  1              to bridge
//  READ_WRITE         out  1              to bridge, 1=read, 0=write
//  apb_write_paddr    out  ADDR_W         to bridge
//  apb_read_paddr     out  ADDR_W         to bridge
//  apb_write_data     out  DATA_W         to bridge
//  PENABLE            in   1              from bridge, high in ACCESS
//  PREADY             in   1              slave ready, as seen by bridge
//  PSLVERR            in   1              from bridge
//  apb_read_data_out  in   DATA_W         from bridge; registered on the completing edge
// BEHAVIOUR
//  - Reset values: state=IDLE, gnt=0, rsp_valid=0, rsp_err=0, transfer=0, READ_WRITE=1.
//  - Reset values (cont.): addr/data outputs=0, rr pointer=NUM_REQ-1 (so req[0] wins first), timeout cnt=0.
//  - States:
//    - IDLE: if |req, pick the winner round-robin from ptr+1 upward.
//      - Register gnt, write flag, addr, wdata.
//      - Update ptr to the winner.
//      - Go to XFER next cycle.
//    - XFER: transfer=1; command outputs driven from the latched registers.
//      - Read: addr goes on apb_read_paddr.
//      - Write: addr goes on apb_write_paddr and data on apb_write_data; the unused address port is 0.
//      - Complete = PENABLE&PREADY, giving RESP with err=0.
//      - PSLVERR=1 in any XFER cycle gives RESP with err=1.
//      - While PENABLE&~PREADY, increment cnt.
//      - cnt==TIMEOUT-1 with still ~PREADY gives RESP with err=1.
//      - Priority: PSLVERR > complete > timeout.
//    - RESP: transfer=0; rsp_valid=gnt for exactly one cycle; rsp_err from the latched flag.
//      - rsp_rdata = apb_read_data_out on a read, 0 on a write or on error.
//      - Clear cnt; gnt stays set during RESP; go to IDLE, where gnt clears.
//  - Latency: grant 1 cycle after req in IDLE.
//  - Minimum transfer: IDLE, XFER(SETUP), XFER(ACCESS, PREADY=1), RESP, i.e. rsp_valid 3 cycles after req.
//  - One transfer at a time; req changes of the owner during XFER are ignored.
//  - Other requesters wait; a dropped req before its grant is simply not served.
//  - Back-to-back: IDLE always sits between RESP and the next grant; transfer is low at least 2 cycles.
//  - Fairness: with all req high, grants rotate 0,1,..,NUM_REQ-1,0.
//  - PRESET mid-transfer: immediate return to reset values; no rsp_valid issued.
// STRUCTURE
//  - Package apb_ctrl_pkg holds:
//    - state encoding localparams (IDLE/XFER/RESP), ADDR_W/DATA_W defaults
//    - READ=1/WRITE=0 constants
//  - Sub-module rr_arbiter #(N): inputs req and ptr; outputs one-hot winner and its index; purely combinational.
//  - Top holds the FSM, command registers, timeout counter and ptr.
// TESTING
//  1. Single write: req[0]=1, write, addr 9'h105, data 8'hA5, PREADY=1.
//     - Expect apb_write_paddr=105 and apb_write_data=A5 while transfer=1.
//     - Expect rsp_valid=2'b01 3 cycles after req, rsp_err=0.
//  2. Single read: req[1]=1, read, addr 9'h023, slave returns 8'h3C, PREADY=1.
//     - Expect rsp_valid=2'b10, rsp_rdata=3C, READ_WRITE=1 throughout.
//  3. Contention: req=2'b11 held 4 transfers after reset.
//     - Expect grant order 0,1,0,1 with transfer low >=2 cycles between them.
//  4. Wait states: PREADY low 5 ACCESS cycles, then high.
//     - Expect rsp_err=0 and rsp_valid 5 cycles later than in case 1.
//  5. Timeout: TIMEOUT=16, PREADY stuck 0.
//     - Expect transfer to drop after 16 ACCESS cycles.
//     - Expect rsp_err=1, rsp_rdata=0, return to IDLE.
//  6. Reset and error:
//     - PRESET asserted during ACCESS: all outputs reset the same cycle, no rsp_valid.
//     - PSLVERR=1 in SETUP: rsp_err=1.

Source files
------------

// File: rtl/apb_ctrl_pkg.sv
// Shared constants for the APB request scheduler: FSM encoding, bus width defaults
// and the READ_WRITE polarity seen by the bridge.
package apb_ctrl_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    XFER = ST_XFER,
    RESP = ST_RESP
  } state_e;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches from ptr+1 upward (wrapping) and
// returns the first active request as a one-hot vector plus its index.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        gnt_o[cand]  = 1'b1;
        idx_o        = cand;
      end
    end
  end

endmodule

// File: rtl/apb_req_scheduler.sv
// Shares one APB master bridge among NUM_REQ requesters: round-robin grant,
// command latch, completion/error/timeout detection and a one-cycle response.
module apb_req_scheduler
  import apb_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      transfer,
  output logic                      READ_WRITE,
  output logic [ADDR_W-1:0]         apb_write_paddr,
  output logic [ADDR_W-1:0]         apb_read_paddr,
  output logic [DATA_W-1:0]         apb_write_data,
  input  logic                      PENABLE,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  input  logic [DATA_W-1:0]         apb_read_data_out
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_e              state_q;
  logic [NUM_REQ-1:0]  gnt_q, rsp_valid_q;
  logic [IW-1:0]       ptr_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   rsp_rdata_q, wdata_q;
  logic                rsp_err_q, transfer_q, rw_q;
  logic [ADDR_W-1:0]   waddr_q, raddr_q;

  logic [NUM_REQ-1:0]  win_gnt;
  logic [IW-1:0]       win_idx;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;
  logic                win_write;
  logic                complete, timed_out, finish;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx)
  );

  assign win_addr  = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
  assign win_wdata = req_wdata[int'(win_idx)*DATA_W +: DATA_W];
  assign win_write = req_write[win_idx];

  // Slave error outranks completion, which outranks the timeout.
  assign complete  = PENABLE & PREADY;
  assign timed_out = PENABLE & ~PREADY & (cnt_q == CW'(TIMEOUT - 1));
  assign finish    = PSLVERR | complete | timed_out;
  assign cnt_d     = cnt_q + CW'(1);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      transfer_q  <= 1'b0;
      rw_q        <= READ;
      waddr_q     <= '0;
      raddr_q     <= '0;
      wdata_q     <= '0;
      ptr_q       <= IW'(NUM_REQ - 1);
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q    <= XFER;
            gnt_q      <= win_gnt;
            ptr_q      <= win_idx;
            transfer_q <= 1'b1;
            rw_q       <= win_write ? WRITE : READ;
            waddr_q    <= win_write ? win_addr : '0;
            raddr_q    <= win_write ? '0 : win_addr;
            wdata_q    <= win_write ? win_wdata : '0;
          end
        end
        XFER: begin
          if (finish) begin
            state_q     <= RESP;
            transfer_q  <= 1'b0;
            rsp_valid_q <= gnt_q;
            rsp_err_q   <= PSLVERR | ~complete;
            rsp_rdata_q <= (!PSLVERR && complete && rw_q == READ) ? apb_read_data_out : '0;
            rw_q        <= READ;
            waddr_q     <= '0;
            raddr_q     <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
          end else if (PENABLE && !PREADY) begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          state_q     <= IDLE;
          gnt_q       <= '0;
          rsp_valid_q <= '0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
          cnt_q       <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt             = gnt_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_err         = rsp_err_q;
  assign transfer        = transfer_q;
  assign READ_WRITE      = rw_q;
  assign apb_write_paddr = waddr_q;
  assign apb_read_paddr  = raddr_q;
  assign apb_write_data  = wdata_q;

endmodule

// File: tb/tb_apb_req_scheduler.sv
// Bench for apb_req_scheduler: small APB bridge/slave model, table of single
// transfers, plus contention, mid-transfer reset and scoreboard of responses.
module tb_apb_req_scheduler;

  localparam int N  = 2;
  localparam int TO = 16;
  localparam int AW = 9;
  localparam int DW = 8;

  logic            PCLK = 1'b0;
  logic            PRESET = 1'b1;
  logic [N-1:0]    req = '0, req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    gnt, rsp_valid;
  logic [DW-1:0]   rsp_rdata, apb_write_data, apb_read_data_out;
  logic            rsp_err, transfer, READ_WRITE;
  logic [AW-1:0]   apb_write_paddr, apb_read_paddr;
  logic            PENABLE, PREADY, PSLVERR;

  always #5 PCLK = ~PCLK;

  apb_req_scheduler #(.NUM_REQ(N), .TIMEOUT(TO), .ADDR_W(AW), .DATA_W(DW)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .transfer(transfer),
    .READ_WRITE(READ_WRITE), .apb_write_paddr(apb_write_paddr),
    .apb_read_paddr(apb_read_paddr), .apb_write_data(apb_write_data),
    .PENABLE(PENABLE), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .apb_read_data_out(apb_read_data_out)
  );

  // Bridge model: one SETUP cycle, then ACCESS with PENABLE until PREADY.
  logic     pen;
  int       acc;
  int       waits_cfg = 0;
  bit       slverr_cfg = 0;
  logic [7:0] sdata = 8'h00;

  assign PENABLE           = pen;
  assign PREADY            = pen && (acc >= waits_cfg);
  assign PSLVERR           = slverr_cfg && transfer && !pen;
  assign apb_read_data_out = sdata;

  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      pen <= 1'b0; acc <= 0;
    end else if (!transfer) begin
      pen <= 1'b0; acc <= 0;
    end else if (!pen) begin
      pen <= 1'b1; acc <= 0;
    end else if (PREADY) begin
      pen <= 1'b0;
    end else begin
      acc <= acc + 1;
    end
  end

  typedef struct {
    int         idx;
    bit         wr;
    logic [8:0] addr;
    logic [7:0] wdata;
    logic [7:0] sdat;
    int         waits;
    bit         slverr;
    int         exp_lat;
    bit         exp_err;
    logic [7:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [1:0] valid;
    logic       err;
    logic [7:0] rdata;
    int         lat;
  } resp_t;

  resp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic got_resp(input int lat);
    resp_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_rsp: got rsp_valid %0b with no expected response", rsp_valid);
    end else begin
      e = exp_q.pop_front();
      check("rsp_valid", rsp_valid, e.valid);
      check("rsp_err", rsp_err, e.err);
      check("rsp_rdata", rsp_rdata, e.rdata);
      if (e.lat >= 0) check("latency", lat, e.lat);
    end
    $display("[TB] rsp valid=%0b err=%0b rdata=%02h lat=%0d", rsp_valid, rsp_err, rsp_rdata, lat);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_transfer"}, transfer, 0);
    check({tag, "_read_write"}, READ_WRITE, 1);
    check({tag, "_wpaddr"}, apb_write_paddr, 0);
    check({tag, "_rpaddr"}, apb_read_paddr, 0);
    check({tag, "_wdata"}, apb_write_data, 0);
  endtask

  task automatic drive_req(input vec_t v);
    waits_cfg  = v.waits;
    slverr_cfg = v.slverr;
    sdata      = v.sdat;
    req_write  = '0;
    req_addr   = '0;
    req_wdata  = '0;
    req_write[v.idx]            = v.wr;
    req_addr[v.idx*AW +: AW]    = v.addr;
    req_wdata[v.idx*DW +: DW]   = v.wdata;
    req        = '0;
    req[v.idx] = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    resp_t e;
    int    cyc;
    bit    seen_x, done;
    @(negedge PCLK);
    drive_req(v);
    e.valid = 2'b01 << v.idx;
    e.err   = v.exp_err;
    e.rdata = v.exp_rdata;
    e.lat   = v.exp_lat;
    exp_q.push_back(e);
    cyc = 0; seen_x = 0; done = 0;
    while (!done && cyc < 60) begin
      @(posedge PCLK); #1;
      cyc++;
      if (transfer) begin
        check("read_write", READ_WRITE, !v.wr);
        if (!seen_x) begin
          seen_x = 1;
          check("gnt", gnt, 2'b01 << v.idx);
          check("wpaddr", apb_write_paddr, v.wr ? v.addr : 9'h000);
          check("rpaddr", apb_read_paddr, v.wr ? 9'h000 : v.addr);
          check("wdata", apb_write_data, v.wr ? v.wdata : 8'h00);
        end
      end
      if (rsp_valid != 0) begin
        got_resp(cyc);
        done = 1;
      end
    end
    if (!done) check("rsp_wait_budget", 0, 1);
    req = '0;
    @(posedge PCLK); #1;
    check("idle_transfer", transfer, 0);
    check("idle_rsp_valid", rsp_valid, 0);
    check("idle_gnt", gnt, 0);
  endtask

  task automatic apply_reset();
    @(negedge PCLK);
    PRESET = 1'b1;
    req    = '0;
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, grants, low, rsp_n;
    bit prev, seen;
    vec_t v;
    //            idx wr addr     wdata  sdat   waits slv lat err rdata
    vecs[0] = '{0, 1, 9'h105, 8'hA5, 8'h00, 0,    0,  3,  0,  8'h00};
    vecs[1] = '{1, 0, 9'h023, 8'h00, 8'h3C, 0,    0,  3,  0,  8'h3C};
    vecs[2] = '{0, 1, 9'h105, 8'hA5, 8'h00, 5,    0,  8,  0,  8'h00};
    vecs[3] = '{1, 0, 9'h0F0, 8'h00, 8'h5A, 1000, 0,  18, 1,  8'h00};
    vecs[4] = '{0, 0, 9'h044, 8'h00, 8'h77, 0,    1,  2,  1,  8'h00};
    vecs[5] = '{1, 1, 9'h1FF, 8'h00, 8'h00, 0,    0,  3,  0,  8'h00};
    vecs[6] = '{0, 0, 9'h100, 8'h00, 8'hFF, 2,    0,  5,  0,  8'hFF};

    repeat (2) @(posedge PCLK);
    #1;
    check_reset_outputs("reset");
    @(negedge PCLK);
    PRESET = 1'b0;

    foreach (vecs[i]) begin
      $display("[TB] vector %0d idx=%0d wr=%0b addr=%03h waits=%0d slverr=%0b",
               i, vecs[i].idx, vecs[i].wr, vecs[i].addr, vecs[i].waits, vecs[i].slverr);
      run_vec(vecs[i]);
    end

    // Contention from reset: grants must go 0,1,0,1 with >=2 idle cycles between.
    apply_reset();
    waits_cfg  = 0;
    slverr_cfg = 0;
    req_write  = '1;
    req_addr   = {9'h1AA, 9'h055};
    req_wdata  = {8'h22, 8'h11};
    for (int k = 0; k < 4; k++) exp_q.push_back('{valid: 2'b01 << (k % 2), err: 1'b0, rdata: 8'h00, lat: -1});
    req = '1;
    cyc = 0; grants = 0; low = 0; rsp_n = 0; prev = 0;
    while (rsp_n < 4 && cyc < 100) begin
      @(posedge PCLK); #1;
      cyc++;
      if (transfer && !prev) begin
        $display("[TB] contention grant %0d gnt=%0b gap=%0d", grants, gnt, low);
        check("rr_gnt", gnt, 2'b01 << (grants % 2));
        if (grants > 0) check("xfer_gap_ge2", 32'(low >= 2), 1);
        grants++;
      end
      low  = transfer ? 0 : low + 1;
      prev = transfer;
      if (rsp_valid != 0) begin
        got_resp(-1);
        rsp_n++;
        if (rsp_n == 4) req = '0;
      end
    end
    check("contention_rsp_count", rsp_n, 4);
    @(posedge PCLK); #1;
    check("contention_idle", transfer, 0);

    // Reset asserted during ACCESS: outputs clear at once, no response follows.
    @(negedge PCLK);
    v = '{0, 0, 9'h0AB, 8'h00, 8'h99, 1000, 0, 0, 0, 8'h00};
    drive_req(v);
    cyc = 0;
    while (!pen && cyc < 10) begin
      @(posedge PCLK); #1;
      cyc++;
    end
    check("reached_access", pen, 1);
    #2 PRESET = 1'b1;
    #1;
    $display("[TB] reset during access at %0t", $time);
    check_reset_outputs("midreset");
    @(negedge PCLK);
    req    = '0;
    PRESET = 1'b0;
    seen   = 0;
    repeat (20) begin
      @(posedge PCLK); #1;
      if (rsp_valid != 0 || transfer) seen = 1;
    end
    check("no_rsp_after_reset", seen, 0);

    // Recovery after reset: requester 1 alone is still served normally.
    run_vec(vecs[1]);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
